// File: rtl/lfsr_mult_bist.sv
// lfsr_mult_bist: self-test controller for multiplier cores.
// A Fibonacci LFSR supplies operand pairs. Each pair is held for HOLD cycles.
// The product is sampled LATENCY cycles after the pair is applied and folded
// into a MISR. At the end of the run the MISR is compared against a golden
// signature.
module lfsr_mult_bist #(
   parameter int unsigned        WIDTH       = 16,
   parameter logic [WIDTH-1:0]   TAPS        = 16'h002D,
   parameter logic [WIDTH-1:0]   SEED        = 16'hACE1,
   parameter logic [2*WIDTH-1:0] MISR_TAPS   = 32'h0000_0057,
   parameter int unsigned        HOLD        = 5,
   parameter int unsigned        LATENCY     = 3,
   parameter int unsigned        NUM_PAT     = 256,
   parameter int unsigned        DUT_RST_CYC = 2,
   localparam int unsigned       CNT_W       = $clog2(NUM_PAT + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 swap_a,
   input  logic [2*WIDTH-1:0]   golden,
   output logic                 dut_rst,
   output logic [WIDTH-1:0]     dut_a,
   output logic [WIDTH-1:0]     dut_b,
   input  logic [2*WIDTH-1:0]   dut_result,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH-1:0]   signature,
   output logic [CNT_W-1:0]     pat_count
);

   // A zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [WIDTH-1:0] SEED_EFF =
      (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

   // One counter serves both the reset phase and the per-pattern hold phase.
   localparam int unsigned HCNT_MAX = (HOLD > DUT_RST_CYC) ? HOLD : DUT_RST_CYC;
   localparam int unsigned HCNT_W   = (HCNT_MAX > 1) ? $clog2(HCNT_MAX) : 1;

   localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD - 1);
   localparam logic [HCNT_W-1:0] LAT_CNT   = HCNT_W'(LATENCY);
   localparam logic [HCNT_W-1:0] RSTD_LAST = HCNT_W'(DUT_RST_CYC - 1);
   localparam logic [CNT_W-1:0]  NUM_PAT_C = CNT_W'(NUM_PAT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RSTD  = 2'd1,
      S_APPLY = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q;
   logic [WIDTH-1:0]    lfsr_q;
   logic [2*WIDTH-1:0]  misr_q;
   logic [CNT_W-1:0]    pat_cnt_q;
   logic [HCNT_W-1:0]   hold_cnt_q;
   logic                swap_q;
   logic                dut_rst_q;
   logic [WIDTH-1:0]    dut_a_q;
   logic [WIDTH-1:0]    dut_b_q;
   logic                busy_q;
   logic                done_q;
   logic                pass_q;

   logic [WIDTH-1:0]    lfsr_adv;
   logic [WIDTH-1:0]    op_src;
   logic [WIDTH-1:0]    op_a;
   logic [2*WIDTH-1:0]  misr_capt;
   logic [2*WIDTH-1:0]  misr_after;
   logic [CNT_W-1:0]    pat_cnt_after;
   logic                capture;
   logic                hold_last;
   logic                last_pat;

   // Datapath: LFSR/MISR step values and the operand pair for the next load.
   always_comb begin
      lfsr_adv  = {^(lfsr_q & TAPS), lfsr_q[WIDTH-1:1]};
      misr_capt = {misr_q[2*WIDTH-2:0], ^(misr_q & MISR_TAPS)} ^ dut_result;
      capture   = (state_q == S_APPLY) && (hold_cnt_q == LAT_CNT);
      hold_last = (state_q == S_APPLY) && (hold_cnt_q == HOLD_LAST);
      // When LATENCY == HOLD-1 the last capture and the end-of-hold decision
      // fall on the same edge. The decision therefore looks at post-capture
      // values.
      misr_after    = capture ? misr_capt : misr_q;
      pat_cnt_after = capture ? (pat_cnt_q + CNT_W'(1)) : pat_cnt_q;
      last_pat      = (pat_cnt_after == NUM_PAT_C);
      // The first pattern uses the seed held in lfsr_q. Later patterns use
      // the advanced value.
      op_src = (state_q == S_APPLY) ? lfsr_adv : lfsr_q;
      op_a   = swap_q ? {op_src[WIDTH/2-1:0], op_src[WIDTH-1:WIDTH/2]} : op_src;
   end

   // Run sequencer: IDLE -> RSTD -> APPLY -> DONE, with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         lfsr_q     <= SEED_EFF;
         misr_q     <= '0;
         pat_cnt_q  <= '0;
         hold_cnt_q <= '0;
         swap_q     <= 1'b0;
         dut_rst_q  <= 1'b1;
         dut_a_q    <= '0;
         dut_b_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  swap_q     <= swap_a;
                  lfsr_q     <= SEED_EFF;
                  misr_q     <= '0;
                  pat_cnt_q  <= '0;
                  hold_cnt_q <= '0;
                  dut_rst_q  <= 1'b1;
                  dut_a_q    <= '0;
                  dut_b_q    <= '0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  pass_q     <= 1'b0;
                  state_q    <= S_RSTD;
               end
            end

            S_RSTD: begin
               if (hold_cnt_q == RSTD_LAST) begin
                  hold_cnt_q <= '0;
                  dut_rst_q  <= 1'b0;
                  dut_b_q    <= op_src;
                  dut_a_q    <= op_a;
                  state_q    <= S_APPLY;
               end else begin
                  hold_cnt_q <= hold_cnt_q + HCNT_W'(1);
               end
            end

            S_APPLY: begin
               if (capture) begin
                  misr_q    <= misr_capt;
                  pat_cnt_q <= pat_cnt_after;
               end
               if (hold_last) begin
                  if (last_pat) begin
                     // Operands keep their last value. The signature freezes
                     // from here on.
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (misr_after == golden);
                     state_q <= S_DONE;
                  end else begin
                     lfsr_q     <= lfsr_adv;
                     dut_b_q    <= op_src;
                     dut_a_q    <= op_a;
                     hold_cnt_q <= '0;
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q + HCNT_W'(1);
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dut_rst   = dut_rst_q;
   assign dut_a     = dut_a_q;
   assign dut_b     = dut_b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = misr_q;
   assign pat_count = pat_cnt_q;

endmodule
